// File: rtl/bypass_scoreboard.sv
// Purpose : register scoreboard with operand bypass selection for an in-order issue stage.
// Latency : issue_stall/src_data are combinational (zero cycle); pending counts update on the next clk edge.
// Backpr. : issue_stall holds the instruction in decode on unresolved sources or a saturated writer count.
//
// Ports:
//   clk, rst          - single clock, asynchronous active-high reset
//   flush             - discard all in-flight writers (pending counts cleared next edge)
//   issue_*           - decoded instruction: valid, write-enable, destination, sources
//   rf_data           - register-file read data, one word per source
//   byp_*             - bypass stages, index 0 youngest; valid/ready/rd/data per stage
//   wb_*              - writeback retiring one writer per cycle
//   issue_stall       - hold instruction in decode
//   src_data          - resolved operand per source
//   stall_cycles      - saturating stall counter, built only with SCOREBOARD_STATS_EN defined
//
// Optional feature: define SCOREBOARD_STATS_EN to build the stall-cycle counter;
// otherwise stall_cycles is tied to zero.

module bypass_scoreboard #(
    parameter  int NUM_REGS = 32,
    parameter  int DATA_W   = 32,
    parameter  int NUM_SRC  = 2,
    parameter  int NUM_BYP  = 2,
    localparam int REG_W    = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             issue_valid,
    input  logic                             issue_we,
    input  logic [REG_W-1:0]                 issue_rd,
    input  logic [NUM_SRC-1:0][REG_W-1:0]    issue_src,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   rf_data,
    input  logic [NUM_BYP-1:0]               byp_valid,
    input  logic [NUM_BYP-1:0]               byp_ready,
    input  logic [NUM_BYP-1:0][REG_W-1:0]    byp_rd,
    input  logic [NUM_BYP-1:0][DATA_W-1:0]   byp_data,
    input  logic                             wb_valid,
    input  logic [REG_W-1:0]                 wb_rd,
    input  logic [DATA_W-1:0]                wb_data,
    output logic                             issue_stall,
    output logic [NUM_SRC-1:0][DATA_W-1:0]   src_data,
    output logic [31:0]                      stall_cycles
);

    // Outstanding-writer count per architectural register; entry 0 never leaves 0.
    logic [1:0] r_pending [NUM_REGS];

    logic [NUM_SRC-1:0]              w_byp_hit;
    logic [NUM_SRC-1:0]              w_byp_rdy;
    logic [NUM_SRC-1:0][DATA_W-1:0]  w_byp_dat;
    logic [NUM_SRC-1:0]              w_src_stall;
    logic                            w_rd_full;
    logic                            w_issue_acc;
    logic [NUM_REGS-1:0]             w_inc;
    logic [NUM_REGS-1:0]             w_dec;

    // Bypass match per source. Stages are scanned oldest to youngest so the
    // youngest matching stage overwrites any older one; a younger writer that
    // is not ready yet therefore masks stale data further down the pipe.
    always_comb begin
        w_byp_hit = '0;
        w_byp_rdy = '0;
        w_byp_dat = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int i = NUM_BYP - 1; i >= 0; i--) begin
                if (byp_valid[i] && (byp_rd[i] == issue_src[s])) begin
                    w_byp_hit[s] = 1'b1;
                    w_byp_rdy[s] = byp_ready[i];
                    w_byp_dat[s] = byp_data[i];
                end
            end
        end
    end

    // Operand resolution priority: x0, bypass, writeback, scoreboard/register file.
    // A stalling source drives 0 so the output is never a stale value.
    always_comb begin
        src_data    = '0;
        w_src_stall = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (issue_src[s] == '0) begin
                src_data[s] = '0;
            end else if (w_byp_hit[s]) begin
                if (w_byp_rdy[s]) begin
                    src_data[s] = w_byp_dat[s];
                end else begin
                    w_src_stall[s] = 1'b1;
                end
            end else if (wb_valid && (wb_rd == issue_src[s])) begin
                src_data[s] = wb_data;
            end else if (r_pending[issue_src[s]] != 2'd0) begin
                // Writer is in flight but outside the bypass window.
                w_src_stall[s] = 1'b1;
            end else begin
                src_data[s] = rf_data[s];
            end
        end
    end

    // A fourth writer cannot be counted unless a retirement frees a slot this cycle.
    always_comb begin
        w_rd_full = issue_we && (issue_rd != '0) && (r_pending[issue_rd] == 2'd3)
                    && !(wb_valid && (wb_rd == issue_rd));
    end

    assign issue_stall = issue_valid && ((|w_src_stall) || w_rd_full);
    assign w_issue_acc = issue_valid && !issue_stall && !flush;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_inc[r] = w_issue_acc && issue_we && (issue_rd == REG_W'(r));
            w_dec[r] = wb_valid && (wb_rd == REG_W'(r));
        end
    end

    // Simultaneous increment and decrement on one register cancel out.
    // Decrement at zero is dropped (writeback of a flushed writer).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pending[r] <= 2'd0;
            end
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pending[r] <= 2'd0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_pending[r] <= r_pending[r] + 2'd1;
                end else if (!w_inc[r] && w_dec[r] && (r_pending[r] != 2'd0)) begin
                    r_pending[r] <= r_pending[r] - 2'd1;
                end
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if (issue_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Purpose : self-checking bench for bypass_scoreboard against a behavioural model.
// Latency : model outputs are combinational from inputs and per-register writer counts.
// Backpr. : stall is computed from source resolution and writer-count saturation.

module tb_bypass_scoreboard;
    localparam int NR = 32;
    localparam int DW = 32;
    localparam int NS = 2;
    localparam int NB = 2;
    localparam int LR = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    issue_valid;
    logic                    issue_we;
    logic [LR-1:0]           issue_rd;
    logic [NS-1:0][LR-1:0]   issue_src;
    logic [NS-1:0][DW-1:0]   rf_data;
    logic [NB-1:0]           byp_valid;
    logic [NB-1:0]           byp_ready;
    logic [NB-1:0][LR-1:0]   byp_rd;
    logic [NB-1:0][DW-1:0]   byp_data;
    logic                    wb_valid;
    logic [LR-1:0]           wb_rd;
    logic [DW-1:0]           wb_data;
    logic                    issue_stall;
    logic [NS-1:0][DW-1:0]   src_data;
    logic [31:0]             stall_cycles;

    int          tests = 0;
    int          fails = 0;
    int          pend [NR];
    logic [31:0] m_cnt = 32'd0;
    bit          cmp_en = 1'b0;

    bypass_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_src(issue_src), .rf_data(rf_data),
        .byp_valid(byp_valid), .byp_ready(byp_ready), .byp_rd(byp_rd), .byp_data(byp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .issue_stall(issue_stall), .src_data(src_data), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each source resolved independently from the rules, counts as plain ints.
    function automatic void model_eval(output bit stall, output logic [NS-1:0][DW-1:0] d,
                                       output bit [NS-1:0] sst);
        int  r;
        int  hit;
        bit  full;
        d   = '0;
        sst = '0;
        for (int s = 0; s < NS; s++) begin
            r   = int'(issue_src[s]);
            hit = -1;
            if (r != 0) begin
                for (int i = 0; i < NB; i++)
                    if (hit < 0 && byp_valid[i] && int'(byp_rd[i]) == r) hit = i;
                if (hit >= 0) begin
                    if (byp_ready[hit]) d[s] = byp_data[hit];
                    else sst[s] = 1'b1;
                end else if (wb_valid && int'(wb_rd) == r) begin
                    d[s] = wb_data;
                end else if (pend[r] > 0) begin
                    sst[s] = 1'b1;
                end else begin
                    d[s] = rf_data[s];
                end
            end
        end
        full  = issue_we && issue_rd != 0 && pend[issue_rd] == 3 && !(wb_valid && wb_rd == issue_rd);
        stall = issue_valid && ((sst != 0) || full);
    endfunction

    // Model state update at each clock edge.
    always @(posedge clk or posedge rst) begin
        bit                    es;
        logic [NS-1:0][DW-1:0] ed;
        bit [NS-1:0]           em;
        int                    inc;
        int                    dec;
        if (rst) begin
            for (int r = 0; r < NR; r++) pend[r] = 0;
            m_cnt = 32'd0;
        end else begin
            model_eval(es, ed, em);
            if (es && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (flush) begin
                for (int r = 0; r < NR; r++) pend[r] = 0;
            end else begin
                inc = (issue_valid && !es && issue_we && issue_rd != 0) ? int'(issue_rd) : -1;
                dec = (wb_valid && wb_rd != 0) ? int'(wb_rd) : -1;
                if (!(inc >= 0 && inc == dec)) begin
                    if (inc >= 0) pend[inc] = pend[inc] + 1;
                    if (dec >= 0 && pend[dec] > 0) pend[dec] = pend[dec] - 1;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit                    es;
        logic [NS-1:0][DW-1:0] ed;
        bit [NS-1:0]           em;
        if (cmp_en) begin
            model_eval(es, ed, em);
            chk("issue_stall", issue_stall, es);
            for (int s = 0; s < NS; s++)
                if (!em[s]) chk("src_data", src_data[s], ed[s]);
`ifdef SCOREBOARD_STATS_EN
            chk("stall_cycles", stall_cycles, m_cnt);
`else
            chk("stall_cycles", stall_cycles, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
        issue_src   = '0;
        rf_data[0]  = $urandom;
        rf_data[1]  = $urandom;
        byp_valid   = '0;
        byp_ready   = '0;
        byp_rd      = '0;
        byp_data    = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    logic [31:0] exp5;

    initial begin
        rst = 1'b1;
        idle();
        cmp_en = 1'b1;
        // Reset state
        issue_valid = 1'b1;
        issue_src[0] = 5'd4;
        issue_src[1] = 5'd2;
        rf_data[0] = 32'h1111_2222;
        #2;
        chk("rst_stall", issue_stall, 1'b0);
        chk("rst_src0", src_data[0], 32'h1111_2222);
        chk("rst_cnt", stall_cycles, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        tick();

        // Youngest stage forwards a ready result
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
        tick();
        idle();
        issue_valid = 1'b1; issue_src[0] = 5'd5;
        byp_valid[0] = 1'b1; byp_rd[0] = 5'd5; byp_ready[0] = 1'b1; byp_data[0] = 32'hA5;
        #1;
        chk("byp0_stall", issue_stall, 1'b0);
        chk("byp0_data", src_data[0], 32'hA5);
        tick();
        do_flush();

        // Younger not-ready stage masks an older ready one
        idle();
        issue_valid = 1'b1; issue_src[0] = 5'd7;
        byp_valid = 2'b11; byp_rd[0] = 5'd7; byp_rd[1] = 5'd7;
        byp_ready = 2'b10; byp_data[1] = 32'h11;
        #1;
        chk("mask_stall", issue_stall, 1'b1);
        tick();
        byp_ready[0] = 1'b1; byp_data[0] = 32'h22;
        #1;
        chk("mask_stall2", issue_stall, 1'b0);
        chk("mask_data", src_data[0], 32'h22);
        tick();
        do_flush();

        // Writer count saturation at 3
        for (int k = 0; k < 3; k++) begin
            idle();
            issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3;
            tick();
        end
        chk("model_pend3", pend[3], 3);
        #1;
        chk("sat_stall", issue_stall, 1'b1);
        wb_valid = 1'b1; wb_rd = 5'd3;
        #1;
        chk("sat_wb_stall", issue_stall, 1'b0);
        tick();
        chk("model_pend3b", pend[3], 3);
        wb_valid = 1'b0;
        #1;
        chk("sat_again", issue_stall, 1'b1);
        tick();
        do_flush();

        // Writeback forwarding and count decrement
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd9;
        tick();
        idle();
        issue_valid = 1'b1; issue_src[0] = 5'd9;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h77;
        #1;
        chk("wb_stall", issue_stall, 1'b0);
        chk("wb_data", src_data[0], 32'h77);
        tick();
        chk("model_pend9", pend[9], 0);
        wb_valid = 1'b0; rf_data[0] = 32'h1234;
        #1;
        chk("wb_after", src_data[0], 32'h1234);
        chk("wb_after_stall", issue_stall, 1'b0);
        tick();

        // x0 sources and flush
        idle();
        issue_valid = 1'b1;
        byp_valid[0] = 1'b1; byp_rd[0] = 5'd0; byp_ready[0] = 1'b1; byp_data[0] = 32'hFF;
        #1;
        chk("x0_stall", issue_stall, 1'b0);
        chk("x0_src0", src_data[0], 32'd0);
        chk("x0_src1", src_data[1], 32'd0);
        tick();
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd6;
        tick();
        idle();
        issue_valid = 1'b1; issue_src[0] = 5'd6; flush = 1'b1;
        #1;
        chk("fl_stall", issue_stall, 1'b1);
        tick();
        flush = 1'b0; rf_data[0] = 32'hBEEF;
        #1;
        chk("fl_after_stall", issue_stall, 1'b0);
        chk("fl_after_data", src_data[0], 32'hBEEF);
        tick();

        // Stall counter and asynchronous reset mid-stall
`ifdef SCOREBOARD_STATS_EN
        exp5 = 32'd5;
`else
        exp5 = 32'd0;
`endif
        idle();
        rst = 1'b1;
        #1;
        chk("arst_cnt0", stall_cycles, 32'd0);
        rst = 1'b0;
        tick();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd10;
        tick();
        idle();
        issue_valid = 1'b1; issue_src[1] = 5'd10;
        for (int k = 0; k < 5; k++) tick();
        chk("stat_stall", issue_stall, 1'b1);
        chk("stat_cnt5", stall_cycles, exp5);
        rst = 1'b1;
        #1;
        chk("arst_stall", issue_stall, 1'b0);
        chk("arst_cnt", stall_cycles, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 4000; n++) begin
            flush        = ($urandom_range(0, 31) == 0);
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_we     = $urandom_range(0, 1);
            issue_rd     = LR'($urandom_range(0, 7));
            issue_src[0] = LR'($urandom_range(0, 7));
            issue_src[1] = LR'($urandom_range(0, 7));
            rf_data[0]   = $urandom;
            rf_data[1]   = $urandom;
            byp_valid    = NB'($urandom_range(0, 3));
            byp_ready    = NB'($urandom_range(0, 3));
            byp_rd[0]    = LR'($urandom_range(0, 7));
            byp_rd[1]    = LR'($urandom_range(0, 7));
            byp_data[0]  = $urandom;
            byp_data[1]  = $urandom;
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_rd        = LR'($urandom_range(0, 7));
            wb_data      = $urandom;
            rst          = ($urandom_range(0, 255) == 0);
            tick();
            rst = 1'b0;
        end

        idle();
        tick();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
